serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b as a + ~b + 1, one bit per cycle, LSB first,
// with ARM-style NZCV flags produced on completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    count;
    logic             carry;

    logic             bit_a;
    logic             bit_b;
    logic             sum;
    logic             cell_carry;
    logic             last;
    logic [WIDTH-1:0] shifted;

    // One-bit full-adder cell on the current operand bit (b inverted for subtraction)
    always_comb begin
        bit_a      = a_reg[count];
        bit_b      = ~b_reg[count];
        sum        = bit_a ^ bit_b ^ carry;
        cell_carry = (bit_a & bit_b) | (carry & (bit_a ^ bit_b));
        shifted    = {sum, result[WIDTH-1:1]};
        last       = (count == CW'(WIDTH - 1));
    end

    // FSM, datapath and registered outputs; reset has priority, start is ignored in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            count     <= '0;
            carry     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else if (start && state != RUN) begin
            state <= RUN;
            a_reg <= a;
            b_reg <= b;
            count <= '0;
            carry <= 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    result <= shifted;
                    carry  <= cell_carry;
                    count  <= count + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        carry_out <= cell_carry;
                        // carry flop still holds the carry into the MSB here
                        overflow  <= carry ^ cell_carry;
                        negative  <= sum;
                        zero      <= (shifted == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor at WIDTH = 64.
module tb_serial_subtractor;

    localparam int unsigned W = 64;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         negative;
    logic         zero;
    logic         overflow;
    logic         carry_out;

    int errors;
    int checks;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start for exactly one rising edge; returns #1 after that edge
    task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (-1 on timeout) and cycles with busy high
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 200) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (!done) edges = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, negative, zero, overflow, carry_out} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, negative, zero, overflow, carry_out});
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int e, bc;
        start_op(64'd5, 64'd3);
        wait_done(e, bc);
        checks++;
        if (e !== 64) begin errors++; $display("FAIL basic_latency: got %0d expected 64", e); end
        checks++;
        if (bc !== 64) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 64", bc); end
        checks++;
        if (result !== 64'd2) begin errors++; $display("FAIL basic_result: got %h expected 2", result); end
        checks++;
        if ({negative, zero, carry_out, overflow} !== 4'b0010) begin
            errors++;
            $display("FAIL basic_nzcv: got %b expected 0010", {negative, zero, carry_out, overflow});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL basic_done_pulse: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_negative();
        int e, bc;
        start_op(64'd3, 64'd5);
        wait_done(e, bc);
        checks++;
        if (e !== 64) begin errors++; $display("FAIL neg_latency: got %0d expected 64", e); end
        checks++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++;
            $display("FAIL neg_result: got %h expected fffffffffffffffe", result);
        end
        checks++;
        if ({negative, zero, carry_out, overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL neg_nzcv: got %b expected 1000", {negative, zero, carry_out, overflow});
        end
    endtask

    // Flags from the previous op (1000) must hold while a new op runs
    task automatic test_hold_flags();
        int e, bc;
        start_op(64'd7, 64'd2);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({busy, negative, zero, carry_out, overflow} !== 5'b11000) begin
            errors++;
            $display("FAIL hold_flags_run: got %b expected 11000",
                     {busy, negative, zero, carry_out, overflow});
        end
        wait_done(e, bc);
        checks++;
        if (e !== 54) begin errors++; $display("FAIL hold_latency: got %0d expected 54", e); end
        checks++;
        if (result !== 64'd5) begin errors++; $display("FAIL hold_result: got %h expected 5", result); end
        checks++;
        if ({negative, zero, carry_out, overflow} !== 4'b0010) begin
            errors++;
            $display("FAIL hold_nzcv: got %b expected 0010", {negative, zero, carry_out, overflow});
        end
    endtask

    task automatic test_overflow();
        int e, bc;
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(e, bc);
        checks++;
        if (e !== 64) begin errors++; $display("FAIL ovf_latency: got %0d expected 64", e); end
        checks++;
        if (result !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL ovf_result: got %h expected 8000000000000000", result);
        end
        checks++;
        if ({negative, zero, carry_out, overflow} !== 4'b1001) begin
            errors++;
            $display("FAIL ovf_nzcv: got %b expected 1001", {negative, zero, carry_out, overflow});
        end
    endtask

    task automatic test_equal();
        int e, bc;
        start_op(64'h1234, 64'h1234);
        wait_done(e, bc);
        checks++;
        if (result !== '0) begin errors++; $display("FAIL equal_result: got %h expected 0", result); end
        checks++;
        if ({negative, zero, carry_out, overflow} !== 4'b0110) begin
            errors++;
            $display("FAIL equal_nzcv: got %b expected 0110", {negative, zero, carry_out, overflow});
        end
        // 0 - 0 after an op that already left zero set: precede with a nonzero op
        start_op(64'd1, 64'd2);
        wait_done(e, bc);
        start_op(64'd0, 64'd0);
        wait_done(e, bc);
        checks++;
        if (e !== 64) begin errors++; $display("FAIL zero_latency: got %0d expected 64", e); end
        checks++;
        if ({result == '0, negative, zero, carry_out, overflow} !== 5'b10110) begin
            errors++;
            $display("FAIL zero_zero: result %h nzcv %b expected 0 / 0110",
                     result, {negative, zero, carry_out, overflow});
        end
    endtask

    task automatic test_ignore_start();
        int e, bc;
        start_op(64'h100, 64'h1);
        repeat (9) @(posedge clk);
        #1;
        a     = 64'hDEAD;
        b     = 64'hBEEF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(e, bc);
        checks++;
        if (e !== 54) begin errors++; $display("FAIL ignore_latency: got %0d expected 54", e); end
        checks++;
        if (result !== 64'hFF) begin errors++; $display("FAIL ignore_result: got %h expected ff", result); end
        checks++;
        if ({negative, zero, carry_out, overflow} !== 4'b0010) begin
            errors++;
            $display("FAIL ignore_nzcv: got %b expected 0010", {negative, zero, carry_out, overflow});
        end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        start_op(64'd20, 64'd30);
        wait_done(e, bc);
        checks++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFF6) begin
            errors++;
            $display("FAIL b2b_first_result: got %h expected fffffffffffffff6", result);
        end
        a     = 64'd40;
        b     = 64'd10;
        start = 1'b1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_with_start: got %b expected 1", done); end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_restart: busy/done got %b expected 10", {busy, done});
        end
        wait_done(e, bc);
        checks++;
        if (e !== 64) begin errors++; $display("FAIL b2b_latency: got %0d expected 64", e); end
        checks++;
        if (result !== 64'd30) begin errors++; $display("FAIL b2b_result: got %h expected 1e", result); end
        checks++;
        if ({negative, zero, carry_out, overflow} !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_nzcv: got %b expected 0010", {negative, zero, carry_out, overflow});
        end
    endtask

    task automatic test_reset_abort();
        int e, bc;
        int done_seen;
        start_op(64'h55, 64'h22);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({busy, done, negative, zero, overflow, carry_out} !== 6'b0) begin
            errors++;
            $display("FAIL abort_ctrl: got %b expected 000000",
                     {busy, done, negative, zero, overflow, carry_out});
        end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL abort_result: got %h expected 0", result); end
        done_seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
        start_op(64'd10, 64'd4);
        wait_done(e, bc);
        checks++;
        if (e !== 64) begin errors++; $display("FAIL abort_new_latency: got %0d expected 64", e); end
        checks++;
        if (result !== 64'd6) begin errors++; $display("FAIL abort_new_result: got %h expected 6", result); end
        checks++;
        if ({negative, zero, carry_out, overflow} !== 4'b0010) begin
            errors++;
            $display("FAIL abort_new_nzcv: got %b expected 0010", {negative, zero, carry_out, overflow});
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_negative();
        test_hold_flags();
        test_overflow();
        test_equal();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
